spectral_flux_256: RTL and testbench

Frame-level spectral-flux stage placed directly downstream of the 256-point FFT. When the FFT's done pulse arrives, it reads FFT bins 0..127 from the FFT working memory. For each bin it computes an L1 magnitude and compares it with the same bin's magnitude from the previous frame. It accumulates the rectified differences into one flux value per frame, which feeds the beat/onset detector.

---
 rtl/sflux_pkg.sv | 25 ++
 rtl/sflux_mag.sv | 24 ++
 rtl/spectral_flux_256.sv | 121 ++++++++++++
 tb/tb_spectral_flux_256.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sflux_pkg.sv
// rtl/sflux_pkg.sv - shared constants, bin word layout and FSM states for spectral_flux_256
package sflux_pkg;

    localparam int N_BINS = 128;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int MAG_W  = 17;
    localparam int FLUX_W = 24;
    localparam int IDX_W  = $clog2(N_BINS);

    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sflux_mag.sv
// rtl/sflux_mag.sv - combinational L1 magnitude |re|+|im| of a Q15 complex bin
module sflux_mag
    import sflux_pkg::*;
(
    input  logic signed [RE_MSB-RE_LSB:0] re,
    input  logic signed [IM_MSB-IM_LSB:0] im,
    output logic        [MAG_W-1:0]       mag
);

    logic [MAG_W-1:0] ext_re;
    logic [MAG_W-1:0] ext_im;
    logic [MAG_W-1:0] abs_re;
    logic [MAG_W-1:0] abs_im;

    // Widen before negating so that |-32768| = 32768 is representable.
    always_comb begin
        ext_re = MAG_W'(re);
        ext_im = MAG_W'(im);
        abs_re = re[RE_MSB-RE_LSB] ? (~ext_re + 1'b1) : ext_re;
        abs_im = im[IM_MSB-IM_LSB] ? (~ext_im + 1'b1) : ext_im;
        mag    = abs_re + abs_im;
    end

endmodule

// File: rtl/spectral_flux_256.sv
// rtl/spectral_flux_256.sv - per-frame spectral flux over FFT bins; SFLUX_HALF_WAVE_EN selects rectified (onset) flux
module spectral_flux_256
    import sflux_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [FLUX_W-1:0] o_flux,
    output logic              o_first
);

    state_t             state;
    logic               drain_cnt;
    logic               first_flag;

    logic               s1_valid;
    logic [IDX_W-1:0]   s1_idx;
    logic               s2_valid;
    logic [IDX_W-1:0]   s2_idx;
    logic [MAG_W-1:0]   s2_mag;

    logic [MAG_W-1:0]   prev [N_BINS];
    logic [FLUX_W-1:0]  acc;
    logic [FLUX_W-1:0]  acc_next;
    logic [MAG_W-1:0]   mag;
    logic signed [MAG_W:0] diff;
    logic [MAG_W-1:0]   contrib;

    sflux_mag u_mag (
        .re  (i_rdata[RE_MSB:RE_LSB]),
        .im  (i_rdata[IM_MSB:IM_LSB]),
        .mag (mag)
    );

    assign o_rd_en = (state == READ);
    assign o_busy  = (state != IDLE);
    assign o_done  = (state == DONE);

    always_comb begin
        diff = $signed({1'b0, s2_mag}) - $signed({1'b0, prev[s2_idx]});
`ifdef SFLUX_HALF_WAVE_EN
        contrib = diff[MAG_W] ? '0 : diff[MAG_W-1:0];
`else
        contrib = diff[MAG_W] ? MAG_W'(-diff) : diff[MAG_W-1:0];
`endif
        acc_next = acc + FLUX_W'(contrib);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            o_addr     <= '0;
            drain_cnt  <= 1'b0;
            first_flag <= 1'b1;
            o_flux     <= '0;
            o_first    <= 1'b0;
            acc        <= '0;
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s2_valid   <= 1'b0;
            s2_idx     <= '0;
            s2_mag     <= '0;
            for (int k = 0; k < N_BINS; k++) begin
                prev[k] <= '0;
            end
        end else begin
            // Stage 1 registers the magnitude of the word returned for the previous address.
            s1_valid <= (state == READ);
            s1_idx   <= o_addr[IDX_W-1:0];
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            s2_mag   <= mag;

            if (s2_valid) begin
                prev[s2_idx] <= s2_mag;
                acc          <= acc_next;
            end

            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= READ;
                        o_addr <= '0;
                        acc    <= '0;
                    end
                end
                READ: begin
                    if (o_addr == LAST_ADDR) begin
                        state     <= DRAIN;
                        drain_cnt <= 1'b0;
                    end else begin
                        o_addr <= o_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last bin accumulates in this cycle, so publish acc_next directly.
                    if (drain_cnt) begin
                        state      <= DONE;
                        o_flux     <= s2_valid ? acc_next : acc;
                        o_first    <= first_flag;
                        first_flag <= 1'b0;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spectral_flux_256.sv
// tb/tb_spectral_flux_256.sv - self-checking bench for spectral_flux_256 and sflux_mag
module tb_spectral_flux_256;
    import sflux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        busy;
    logic        done;
    logic [23:0] flux;
    logic        first;

    spectral_flux_256 dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .o_rd_en (rd_en),
        .o_addr  (addr),
        .i_rdata (rdata),
        .o_busy  (busy),
        .o_done  (done),
        .o_flux  (flux),
        .o_first (first)
    );

    logic signed [15:0] m_re;
    logic signed [15:0] m_im;
    logic [16:0]        m_mag;

    sflux_mag u_mag_ut (
        .re  (m_re),
        .im  (m_im),
        .mag (m_mag)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        bit          ramp;
        bit          rst_before;
        int          pa;
        int          pb;
        bit          chain;
        logic [23:0] exp_flux;
        bit          exp_first;
    } frame_t;

    typedef struct {
        logic [23:0] flux;
        bit          first;
    } exp_t;

    typedef struct {
        logic [15:0] re;
        logic [15:0] im;
        logic [16:0] mag;
    } mag_vec_t;

    frame_t   tbl [8];
    mag_vec_t mtbl[5];
    exp_t     sb[$];

    logic [15:0] cur_re = 16'd0;
    logic [15:0] cur_im = 16'd0;
    bit          cur_ramp = 1'b0;
    bit          pend = 1'b0;
    logic [7:0]  pend_addr = 8'd0;
    bit          start_pending = 1'b0;

    function automatic logic [31:0] word_for(input logic [7:0] a);
        if (cur_ramp) return {8'h00, a, 16'h0000};
        return {cur_re, cur_im};
    endfunction

    // Memory model: data for an address appears one cycle after its read strobe, junk otherwise.
    always @(negedge clk) begin
        if (pend) rdata = word_for(pend_addr);
        else      rdata = 32'hDEAD_BEEF;
        pend      = rd_en;
        pend_addr = addr;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input int idx, input logic [15:0] re, input logic [15:0] im,
                             input bit ramp, input logic [23:0] ef, input bit efirst,
                             input int pa, input int pb, input bit chain);
        int   done_cnt = 0;
        int   done_at  = -1;
        int   rd_cnt   = 0;
        int   addr_err = 0;
        int   busy_err = 0;
        exp_t e;
        cur_re   = re;
        cur_im   = im;
        cur_ramp = ramp;
        if (!start_pending) begin
            @(negedge clk);
            start = 1'b1;
        end
        start_pending = 1'b0;
        sb.push_back('{ef, efirst});
        for (int cyc = 1; cyc <= 134; cyc++) begin
            @(negedge clk);
            start = (cyc == pa) || (cyc == pb);
            if (rd_en === 1'b1) begin
                rd_cnt++;
                if (addr !== 8'(cyc - 1) || cyc > 128) addr_err++;
            end else if (cyc > 128 && addr !== 8'd127) begin
                addr_err++;
            end
            if (busy !== (cyc <= 131)) busy_err++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = cyc;
                if (sb.size() == 0) begin
                    check($sformatf("f%0d_sb_underflow", idx), 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("f%0d_flux", idx), {8'h0, flux}, {8'h0, e.flux});
                    check($sformatf("f%0d_first", idx), {31'h0, first}, {31'h0, e.first});
                end
            end
            if (chain && cyc == 132) begin
                start = 1'b1;
                start_pending = 1'b1;
                break;
            end
        end
        check($sformatf("f%0d_done_count", idx), done_cnt, 1);
        check($sformatf("f%0d_done_cycle", idx), done_at, 131);
        check($sformatf("f%0d_rd_en_cycles", idx), rd_cnt, 128);
        check($sformatf("f%0d_addr_seq_errs", idx), addr_err, 0);
        check($sformatf("f%0d_busy_errs", idx), busy_err, 0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_rd_en"}, {31'h0, rd_en}, 32'd0);
        check({tag, "_addr"},  {24'h0, addr},  32'd0);
        check({tag, "_busy"},  {31'h0, busy},  32'd0);
        check({tag, "_done"},  {31'h0, done},  32'd0);
        check({tag, "_flux"},  {8'h0, flux},   32'd0);
        check({tag, "_first"}, {31'h0, first}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        rdata = 32'd0;
        m_re  = 16'sd0;
        m_im  = 16'sd0;

        mtbl[0] = '{16'h0000, 16'h0000, 17'd0};
        mtbl[1] = '{16'h8000, 16'h8000, 17'd65536};
        mtbl[2] = '{16'h7FFF, 16'h8000, 17'd65535};
        mtbl[3] = '{16'hFFFF, 16'h0001, 17'd2};
        mtbl[4] = '{16'd100,  16'hFFCE, 17'd150};

`ifdef SFLUX_HALF_WAVE_EN
        tbl[0] = '{16'd100,  16'hFFCE, 1'b0, 1'b0, 0,  0,   1'b0, 24'd19200,   1'b1};
        tbl[1] = '{16'd100,  16'hFFCE, 1'b0, 1'b0, 50, 131, 1'b1, 24'd0,       1'b0};
        tbl[2] = '{16'd200,  16'd0,    1'b0, 1'b0, 0,  0,   1'b0, 24'd6400,    1'b0};
        tbl[3] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd0,       1'b0};
        tbl[4] = '{16'd0,    16'd0,    1'b1, 1'b0, 0,  0,   1'b0, 24'd0,       1'b0};
        tbl[5] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd11072,   1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 0,  0,   1'b0, 24'h800000,  1'b1};
        tbl[7] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd0,       1'b0};
`else
        tbl[0] = '{16'd100,  16'hFFCE, 1'b0, 1'b0, 0,  0,   1'b0, 24'd19200,   1'b1};
        tbl[1] = '{16'd100,  16'hFFCE, 1'b0, 1'b0, 50, 131, 1'b1, 24'd0,       1'b0};
        tbl[2] = '{16'd200,  16'd0,    1'b0, 1'b0, 0,  0,   1'b0, 24'd6400,    1'b0};
        tbl[3] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd6400,    1'b0};
        tbl[4] = '{16'd0,    16'd0,    1'b1, 1'b0, 0,  0,   1'b0, 24'd11072,   1'b0};
        tbl[5] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd11072,   1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 0,  0,   1'b0, 24'h800000,  1'b1};
        tbl[7] = '{16'd100,  16'd50,   1'b0, 1'b0, 0,  0,   1'b0, 24'd8369408, 1'b0};
`endif

        for (int i = 0; i < 5; i++) begin
            m_re = mtbl[i].re;
            m_im = mtbl[i].im;
            #1;
            check($sformatf("mag_vec%0d", i), {15'h0, m_mag}, {15'h0, mtbl[i].mag});
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_idle_zero("reset");

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_frame(i, tbl[i].re, tbl[i].im, tbl[i].ramp, tbl[i].exp_flux, tbl[i].exp_first,
                      tbl[i].pa, tbl[i].pb, tbl[i].chain);
        end

        // Reset in cycle 60 of a frame aborts it.
        cur_re   = 16'd100;
        cur_im   = 16'd50;
        cur_ramp = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 60) rst = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("midreset");

        // Start coincident with reset is dropped.
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'h0, busy}, 32'd0);
        @(negedge clk);
        check("rst_start_busy2", {31'h0, busy}, 32'd0);
        check("rst_start_rd_en", {31'h0, rd_en}, 32'd0);

        run_frame(8, 16'd100, 16'd50, 1'b0, 24'd19200, 1'b1, 0, 0, 1'b0);

        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
